// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around an external combinational 16-bit ALU.
// Operands come from a local register file with a writeback-slot bypass;
// ALU results are captured into a single writeback slot that retires into
// the register file and out on a valid/ready result stream.
module alu_issue_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [REG_AW-1:0] in_rs,
   input  logic [REG_AW-1:0] in_rt,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [REG_AW-1:0] res_rd,
   output logic [DATA_W-1:0] res_data,
   output logic              err,
   output logic [15:0]       retired
);

   localparam int unsigned NREG  = 1 << REG_AW;
   localparam int unsigned CNT_W = 16;

   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] rf_d [NREG];
   logic              res_valid_q, res_valid_d;
   logic [REG_AW-1:0] res_rd_q,    res_rd_d;
   logic [DATA_W-1:0] res_data_q,  res_data_d;
   logic              err_q,       err_d;
   logic [CNT_W-1:0]  retired_q,   retired_d;

   logic accept_c;
   logic legal_c;
   logic retire_c;

   // Operand value: r0 is hardwired zero, a live slot result wins over the RF
   function automatic logic [DATA_W-1:0] read_op(
      input logic [REG_AW-1:0] r,
      input logic [DATA_W-1:0] rf_val,
      input logic              slot_valid,
      input logic [REG_AW-1:0] slot_rd,
      input logic [DATA_W-1:0] slot_data
   );
      logic [DATA_W-1:0] v;
      if (r == '0)                         v = '0;
      else if (slot_valid && slot_rd == r) v = slot_data;
      else                                 v = rf_val;
      return v;
   endfunction

   // Handshake and ALU drive
   always_comb begin
      in_ready = !res_valid_q || res_ready;
      alu_op   = in_op;
      alu_a    = read_op(in_rs, rf_q[in_rs], res_valid_q, res_rd_q, res_data_q);
      alu_b    = read_op(in_rt, rf_q[in_rt], res_valid_q, res_rd_q, res_data_q);
      accept_c = in_valid && in_ready;
      legal_c  = (in_op[3:2] == 2'b00);
      retire_c = res_valid_q && res_ready;
   end

   // Next state: retire first, then an accept on the same edge may refill the slot
   always_comb begin
      rf_d        = rf_q;
      res_valid_d = res_valid_q;
      res_rd_d    = res_rd_q;
      res_data_d  = res_data_q;
      err_d       = err_q;
      retired_d   = retired_q;

      if (retire_c) begin
         res_valid_d = 1'b0;
         retired_d   = retired_q + CNT_W'(1);
         if (res_rd_q != '0) rf_d[res_rd_q] = res_data_q;
      end

      if (accept_c) begin
         if (legal_c) begin
            res_valid_d = 1'b1;
            res_rd_d    = in_rd;
            res_data_d  = alu_out;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
         res_valid_q <= 1'b0;
         res_rd_q    <= '0;
         res_data_q  <= '0;
         err_q       <= 1'b0;
         retired_q   <= '0;
      end else begin
         rf_q        <= rf_d;
         res_valid_q <= res_valid_d;
         res_rd_q    <= res_rd_d;
         res_data_q  <= res_data_d;
         err_q       <= err_d;
         retired_q   <= retired_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_rd    = res_rd_q;
   assign res_data  = res_data_q;
   assign err       = err_q;
   assign retired   = retired_q;

endmodule
